// File: rtl/pic_prio_sched.sv
// PIC priority resolver: holds IRR/ISR, picks the winning level under fixed/rotating priority
// and runs the two-pulse INTA handshake. Build macro SPECIAL_MASK_EN adds the smm input.
module pic_prio_sched #(
  parameter int unsigned NLVL     = 8,
  parameter int unsigned SPUR_LVL = 7
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [NLVL-1:0] ir,
  input  logic [NLVL-1:0] imr,
  input  logic            ltim,
  input  logic            aeoi,
  input  logic            rot_aeoi,
  input  logic            eoi_cmd,
  input  logic            eoi_spec,
  input  logic            eoi_rot,
  input  logic [2:0]      eoi_level,
  input  logic            set_prio,
  input  logic            inta_n,
  input  logic [4:0]      vec_base,
`ifdef SPECIAL_MASK_EN
  input  logic            smm,
`endif
  output logic            int_o,
  output logic [7:0]      vec_o,
  output logic            vec_valid,
  output logic [NLVL-1:0] isr_o,
  output logic [NLVL-1:0] irr_o,
  output logic [2:0]      bottom_o
);
  localparam int unsigned LW = 3;

  typedef enum logic [1:0] {IDLE, REQ, ACK1, ACK2} state_t;

  // Highest-priority set bit of v, scanning upward from bottom+1; returns {found, level}.
  function automatic logic [LW:0] pick(input logic [NLVL-1:0] v, input logic [LW-1:0] bot);
    logic [LW:0]   res;
    logic [LW-1:0] l;
    res = '0;
    for (int unsigned k = 0; k < NLVL; k++) begin
      l = bot + LW'(k + 1);
      if (!res[LW] && v[l]) res = {1'b1, l};
    end
    return res;
  endfunction

  // Distance from the top of the priority order; 0 is highest.
  function automatic logic [LW-1:0] rank(input logic [LW-1:0] lvl, input logic [LW-1:0] bot);
    return lvl - bot - LW'(1);
  endfunction

  state_t          r_state, w_state_nx;
  logic [NLVL-1:0] r_irr, r_isr, r_ir_q;
  logic [NLVL-1:0] w_irr_nx, w_isr_nx, w_isr_vis, w_set, w_clr, w_aeoi_clr;
  logic [LW-1:0]   r_bottom, r_lvl, w_bottom_nx, w_eoi_lvl;
  logic [LW:0]     w_cand, w_top, w_ns;
  logic [7:0]      r_vec;
  logic            r_spur, r_inta_q, r_vec_valid, w_vv_nx;
  logic            w_fall, w_rise, w_int, w_commit, w_vec_load, w_ack_done, w_aeoi_do, w_eoi_hit;

`ifdef SPECIAL_MASK_EN
  assign w_isr_vis = smm ? (r_isr & ~imr) : r_isr;
`else
  assign w_isr_vis = r_isr;
`endif

  assign w_cand    = pick(r_irr & ~imr, r_bottom);
  assign w_top     = pick(w_isr_vis, r_bottom);
  assign w_fall    = r_inta_q & ~inta_n;
  assign w_rise    = ~r_inta_q & inta_n;
  assign w_int     = ((r_state == IDLE) || (r_state == REQ)) && w_cand[LW] &&
                     (!w_top[LW] || (rank(w_cand[LW-1:0], r_bottom) < rank(w_top[LW-1:0], r_bottom)));
  assign w_aeoi_do = w_ack_done & aeoi & ~r_spur;

  // Handshake sequencing
  always_comb begin
    w_state_nx = r_state;
    w_commit   = 1'b0;
    w_vec_load = 1'b0;
    w_ack_done = 1'b0;
    w_vv_nx    = r_vec_valid;
    case (r_state)
      IDLE: if (w_int) w_state_nx = REQ;
      REQ: begin
        if (w_fall) begin
          w_state_nx = ACK1;
          w_commit   = 1'b1;
        end else if (!w_int) begin
          w_state_nx = IDLE;
        end
      end
      ACK1: begin
        if (w_fall) begin
          w_state_nx = ACK2;
          w_vec_load = 1'b1;
          w_vv_nx    = 1'b1;
        end
      end
      ACK2: begin
        if (w_rise) begin
          w_state_nx = IDLE;
          w_vv_nx    = 1'b0;
          w_ack_done = 1'b1;
        end
      end
      default: w_state_nx = IDLE;
    endcase
  end

  // ISR/IRR/bottom updates; a commit set beats any clear on the same bit
  always_comb begin
    w_set       = '0;
    w_aeoi_clr  = '0;
    w_eoi_hit   = 1'b0;
    w_eoi_lvl   = eoi_level;
    w_bottom_nx = r_bottom;
    if (w_commit && w_cand[LW]) w_set = NLVL'(1) << w_cand[LW-1:0];
    if (w_aeoi_do) w_aeoi_clr = NLVL'(1) << r_lvl;
    w_ns = pick(w_isr_vis & ~w_aeoi_clr, r_bottom);
    if (eoi_cmd) begin
      if (eoi_spec) begin
        w_eoi_hit = 1'b1;
      end else if (w_ns[LW]) begin
        w_eoi_hit = 1'b1;
        w_eoi_lvl = w_ns[LW-1:0];
      end
    end
    w_clr = w_aeoi_clr;
    if (w_eoi_hit) w_clr = w_clr | (NLVL'(1) << w_eoi_lvl);
    if (w_eoi_hit && eoi_rot)      w_bottom_nx = w_eoi_lvl;
    else if (set_prio && !eoi_cmd) w_bottom_nx = eoi_level;
    else if (w_aeoi_do && rot_aeoi) w_bottom_nx = r_lvl;
    w_isr_nx = (r_isr & ~w_clr) | w_set;
    w_irr_nx = ltim ? (ir & ~w_set) : ((r_irr & ~w_set) | (ir & ~r_ir_q));
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= IDLE;
      r_irr       <= '0;
      r_isr       <= '0;
      r_bottom    <= LW'(NLVL - 1);
      r_vec       <= '0;
      r_vec_valid <= 1'b0;
      r_ir_q      <= '0;
      r_inta_q    <= 1'b1;
      r_lvl       <= '0;
      r_spur      <= 1'b0;
    end else begin
      r_state     <= w_state_nx;
      r_irr       <= w_irr_nx;
      r_isr       <= w_isr_nx;
      r_bottom    <= w_bottom_nx;
      r_vec_valid <= w_vv_nx;
      r_ir_q      <= ir;
      r_inta_q    <= inta_n;
      if (w_commit) begin
        r_lvl  <= w_cand[LW] ? w_cand[LW-1:0] : LW'(SPUR_LVL);
        r_spur <= ~w_cand[LW];
      end
      if (w_vec_load) r_vec <= {vec_base, r_lvl};
    end
  end

  assign int_o     = w_int;
  assign vec_o     = r_vec;
  assign vec_valid = r_vec_valid;
  assign isr_o     = r_isr;
  assign irr_o     = r_irr;
  assign bottom_o  = r_bottom;

endmodule
